// File: rtl/carfield_l2_periph_router.sv
// Single-master to multi-target request router for the Carfield L2/peripheral
// address map. Requests are decoded and forwarded with zero latency; an order
// FIFO of target indices returns responses strictly in issue order. Addresses
// that hit no window are answered internally with an error response.
module carfield_l2_periph_router #(
  parameter int unsigned NumTgt    = 5,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTxns   = 4,
  parameter logic [NumTgt-1:0] TgtEnable = '1,
  // Index 0 is the rightmost element: L2 port 0, L2 port 1, Spatz, Mailbox, Periph
  parameter logic [NumTgt-1:0][AddrWidth-1:0] TgtBase = {
    64'h0000_0000_2000_1000, 64'h0000_0000_4000_0000, 64'h0000_0000_5100_0000,
    64'h0000_0000_7820_0000, 64'h0000_0000_7800_0000},
  parameter logic [NumTgt-1:0][AddrWidth-1:0] TgtSize = {
    64'h0000_0000_0000_9000, 64'h0000_0000_0000_1000, 64'h0000_0000_0080_0000,
    64'h0000_0000_0020_0000, 64'h0000_0000_0020_0000}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        slv_req_valid_i,
  output logic                        slv_req_ready_o,
  input  logic [AddrWidth-1:0]        slv_req_addr_i,
  input  logic                        slv_req_we_i,
  input  logic [DataWidth-1:0]        slv_req_wdata_i,
  input  logic [DataWidth/8-1:0]      slv_req_be_i,
  output logic                        slv_rsp_valid_o,
  input  logic                        slv_rsp_ready_i,
  output logic [DataWidth-1:0]        slv_rsp_rdata_o,
  output logic                        slv_rsp_err_o,
  output logic [NumTgt-1:0]           mst_req_valid_o,
  input  logic [NumTgt-1:0]           mst_req_ready_i,
  output logic [AddrWidth-1:0]        mst_req_addr_o,
  output logic                        mst_req_we_o,
  output logic [DataWidth-1:0]        mst_req_wdata_o,
  output logic [DataWidth/8-1:0]      mst_req_be_o,
  input  logic [NumTgt-1:0]           mst_rsp_valid_i,
  output logic [NumTgt-1:0]           mst_rsp_ready_o,
  input  logic [NumTgt*DataWidth-1:0] mst_rsp_rdata_i,
  input  logic [NumTgt-1:0]           mst_rsp_err_i,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o
);

  localparam int unsigned SelW = $clog2(NumTgt + 1);
  localparam int unsigned PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NumTgt);

  logic [SelW-1:0] fifo_q [MaxTxns];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [SelW-1:0] sel, head;
  logic            hit_found, miss, full, empty, tgt_rdy, push, pop;

  // Address decode: lowest-index enabled window containing the address wins
  always_comb begin
    sel       = ErrSel;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NumTgt; i++) begin
      if (!hit_found && TgtEnable[i] &&
          ({1'b0, slv_req_addr_i} >= {1'b0, TgtBase[i]}) &&
          ({1'b0, slv_req_addr_i} <  ({1'b0, TgtBase[i]} + {1'b0, TgtSize[i]}))) begin
        sel       = SelW'(i);
        hit_found = 1'b1;
      end
    end
  end

  assign mst_req_addr_o  = slv_req_addr_i;
  assign mst_req_we_o    = slv_req_we_i;
  assign mst_req_wdata_o = slv_req_wdata_i;
  assign mst_req_be_o    = slv_req_be_i;

  assign full  = (cnt_q == CntW'(MaxTxns));
  assign empty = (cnt_q == '0);
  assign miss  = (sel == ErrSel);

  // Request steering and handshake; misses only need FIFO space
  always_comb begin
    mst_req_valid_o = '0;
    tgt_rdy         = 1'b0;
    for (int unsigned i = 0; i < NumTgt; i++) begin
      if (sel == SelW'(i)) begin
        mst_req_valid_o[i] = slv_req_valid_i && !full;
        tgt_rdy            = mst_req_ready_i[i];
      end
    end
    slv_req_ready_o = !full && (miss || tgt_rdy);
    push            = slv_req_valid_i && slv_req_ready_o;
  end

  assign head = fifo_q[rptr_q];

  // Response return from the FIFO head only, keeping issue order across targets
  always_comb begin
    slv_rsp_valid_o = 1'b0;
    slv_rsp_rdata_o = '0;
    slv_rsp_err_o   = 1'b0;
    mst_rsp_ready_o = '0;
    if (!empty) begin
      if (head == ErrSel) begin
        slv_rsp_valid_o = 1'b1;
        slv_rsp_err_o   = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NumTgt; i++) begin
          if (head == SelW'(i)) begin
            slv_rsp_valid_o    = mst_rsp_valid_i[i];
            slv_rsp_rdata_o    = mst_rsp_rdata_i[i*DataWidth +: DataWidth];
            slv_rsp_err_o      = mst_rsp_err_i[i];
            mst_rsp_ready_o[i] = slv_rsp_ready_i;
          end
        end
      end
    end
    pop = slv_rsp_valid_o && slv_rsp_ready_i;
  end

  // Order FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PtrW'(MaxTxns - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PtrW'(MaxTxns - 1)) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Order FIFO state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxTxns; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) fifo_q[wptr_q] <= sel;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_carfield_l2_periph_router.sv
// Bench for carfield_l2_periph_router: behavioural target models, a reference
// address decoder and an in-order response scoreboard.
module tb_carfield_l2_periph_router;
  localparam int NT = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          slv_req_valid, slv_req_ready, slv_req_we;
  logic [63:0]   slv_req_addr, slv_req_wdata;
  logic [7:0]    slv_req_be;
  logic          slv_rsp_valid, slv_rsp_ready, slv_rsp_err;
  logic [63:0]   slv_rsp_rdata;
  logic [NT-1:0] mst_req_valid, mst_req_ready, mst_req_we_unused;
  logic [63:0]   mst_req_addr, mst_req_wdata;
  logic          mst_req_we;
  logic [7:0]    mst_req_be;
  logic [NT-1:0] mst_rsp_valid, mst_rsp_ready, mst_rsp_err;
  logic [NT*64-1:0] mst_rsp_rdata;
  logic [2:0]    outstanding;

  carfield_l2_periph_router #(.NumTgt(5), .AddrWidth(64), .DataWidth(64), .MaxTxns(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_valid_i(slv_req_valid), .slv_req_ready_o(slv_req_ready),
    .slv_req_addr_i(slv_req_addr), .slv_req_we_i(slv_req_we),
    .slv_req_wdata_i(slv_req_wdata), .slv_req_be_i(slv_req_be),
    .slv_rsp_valid_o(slv_rsp_valid), .slv_rsp_ready_i(slv_rsp_ready),
    .slv_rsp_rdata_o(slv_rsp_rdata), .slv_rsp_err_o(slv_rsp_err),
    .mst_req_valid_o(mst_req_valid), .mst_req_ready_i(mst_req_ready),
    .mst_req_addr_o(mst_req_addr), .mst_req_we_o(mst_req_we),
    .mst_req_wdata_o(mst_req_wdata), .mst_req_be_o(mst_req_be),
    .mst_rsp_valid_i(mst_rsp_valid), .mst_rsp_ready_o(mst_rsp_ready),
    .mst_rsp_rdata_i(mst_rsp_rdata), .mst_rsp_err_i(mst_rsp_err),
    .outstanding_o(outstanding)
  );

  // Reference address map
  logic [63:0] ref_base [NT] = '{64'h7800_0000, 64'h7820_0000, 64'h5100_0000, 64'h4000_0000, 64'h2000_1000};
  logic [63:0] ref_size [NT] = '{64'h20_0000, 64'h20_0000, 64'h80_0000, 64'h1000, 64'h9000};

  function automatic int ref_sel(input logic [63:0] a);
    for (int i = 0; i < NT; i++)
      if (a >= ref_base[i] && a < ref_base[i] + ref_size[i]) return i;
    return NT;
  endfunction

  function automatic logic [63:0] rsp_data(input logic [63:0] a);
    return a ^ 64'hC3C3_5A5A_0000_0000;
  endfunction

  function automatic logic rsp_err(input logic [63:0] a);
    return a[7:0] == 8'h08;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Target models: each queues accepted addresses and answers in order
  logic [63:0] tq [NT][8];
  int          tcnt [NT];
  logic [NT-1:0] rsp_en, tgt_rdy;

  task automatic drive_tgt();
    for (int i = 0; i < NT; i++) begin
      mst_req_ready[i] = tgt_rdy[i];
      mst_rsp_valid[i] = rsp_en[i] && (tcnt[i] > 0);
      mst_rsp_rdata[i*64 +: 64] = (tcnt[i] > 0) ? rsp_data(tq[i][0]) : 64'h0;
      mst_rsp_err[i]   = (tcnt[i] > 0) ? rsp_err(tq[i][0]) : 1'b0;
    end
  endtask

  // Scoreboard of expected {err, rdata}
  logic [64:0] sb [$];
  logic acc_s, pop_s, smp_req_ready;
  logic [NT-1:0] smp_req_valid;

  // One clock: sample at negedge, commit model updates just after posedge
  task automatic tick();
    logic [NT-1:0] req_hs, rsp_hs;
    logic [63:0]   a;
    logic [64:0]   e;
    int            s;
    @(negedge clk);
    smp_req_ready = slv_req_ready;
    smp_req_valid = mst_req_valid;
    acc_s = rst_n && slv_req_valid && slv_req_ready;
    pop_s = rst_n && slv_rsp_valid && slv_rsp_ready;
    a = mst_req_addr;
    req_hs = mst_req_valid & mst_req_ready;
    rsp_hs = mst_rsp_valid & mst_rsp_ready;
    if (acc_s) begin
      s = ref_sel(slv_req_addr);
      chk("req_route", {59'd0, mst_req_valid}, (s < NT) ? (64'd1 << s) : 64'd0);
      sb.push_back((s < NT) ? {rsp_err(slv_req_addr), rsp_data(slv_req_addr)} : {1'b1, 64'd0});
    end
    if (pop_s) begin
      if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", slv_rsp_rdata, e[63:0]);
        chk("rsp_err", {63'd0, slv_rsp_err}, {63'd0, e[64]});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NT; i++) begin
      if (rsp_hs[i]) begin
        for (int j = 0; j < 7; j++) tq[i][j] = tq[i][j+1];
        tcnt[i]--;
      end
      if (req_hs[i]) begin
        tq[i][tcnt[i]] = a;
        tcnt[i]++;
      end
    end
    drive_tgt();
  endtask

  task automatic send(input logic [63:0] addr, input logic we);
    int k;
    slv_req_valid = 1'b1;
    slv_req_addr  = addr;
    slv_req_we    = we;
    slv_req_wdata = ~addr;
    k = 0;
    do begin
      tick();
      k++;
    end while (!acc_s && k < 20);
    if (!acc_s) chk("send_timeout", 64'd1, 64'd0);
    slv_req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain_done", sb.size(), 64'd0);
  endtask

  logic [63:0] bnd [4] = '{64'h781F_FFFF, 64'h7820_0000, 64'h2000_9FFF, 64'h2000_A000};
  int pop_cyc, acc_cyc;

  initial begin
    rst_n = 1'b0;
    slv_req_valid = 1'b0; slv_req_addr = '0; slv_req_we = 1'b0;
    slv_req_wdata = '0; slv_req_be = 8'hFF; slv_rsp_ready = 1'b1;
    rsp_en = '1; tgt_rdy = '1;
    for (int i = 0; i < NT; i++) tcnt[i] = 0;
    drive_tgt();
    tick(); tick();
    chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
    chk("rst_rsp_valid", {63'd0, slv_rsp_valid}, 64'd0);
    chk("rst_mst_rsp_ready", {59'd0, mst_rsp_ready}, 64'd0);
    chk("rst_req_ready_miss", {63'd0, slv_req_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Write to L2 port 0
    send(64'h7800_0010, 1'b1);
    chk("wr_outstanding1", {61'd0, outstanding}, 64'd1);
    drain();
    tick();
    chk("wr_outstanding0", {61'd0, outstanding}, 64'd0);

    // Out-of-order target responses returned in issue order
    rsp_en = '0; drive_tgt();
    send(64'h7820_0000, 1'b0);
    send(64'h4000_0008, 1'b0);
    rsp_en[3] = 1'b1; drive_tgt();
    tick(); tick();
    chk("order_t3_stalled", {63'd0, mst_rsp_ready[3]}, 64'd0);
    chk("order_rsp_wait", {63'd0, slv_rsp_valid}, 64'd0);
    rsp_en[1] = 1'b1; drive_tgt();
    drain();

    // Unmapped address answered internally
    send(64'h1000_0000, 1'b0);
    chk("miss_rsp_valid", {63'd0, slv_rsp_valid}, 64'd1);
    chk("miss_rsp_err", {63'd0, slv_rsp_err}, 64'd1);
    chk("miss_rsp_rdata", slv_rsp_rdata, 64'd0);
    drain();

    // Window boundaries
    rsp_en = '1; drive_tgt();
    for (int i = 0; i < 4; i++) send(bnd[i], 1'b0);
    drain();

    // Not-ready target holds off the request
    tgt_rdy[4] = 1'b0; drive_tgt();
    slv_req_valid = 1'b1; slv_req_addr = 64'h2000_1000;
    tick();
    chk("nrdy_req_ready", {63'd0, smp_req_ready}, 64'd0);
    chk("nrdy_req_valid", {59'd0, smp_req_valid}, 64'h10);
    tgt_rdy[4] = 1'b1; drive_tgt();
    send(64'h2000_1000, 1'b0);
    drain();

    // Full FIFO: fifth request waits until the cycle after the first pop
    rsp_en[2] = 1'b0; drive_tgt();
    for (int i = 0; i < 4; i++) send(64'h5100_0000 + 64'(i * 8), 1'b0);
    chk("full_outstanding", {61'd0, outstanding}, 64'd4);
    slv_req_valid = 1'b1; slv_req_addr = 64'h5100_0100;
    tick();
    chk("full_req_ready", {63'd0, smp_req_ready}, 64'd0);
    chk("full_req_valid", {59'd0, smp_req_valid}, 64'd0);
    rsp_en[2] = 1'b1; drive_tgt();
    pop_cyc = -1; acc_cyc = -1;
    for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
      tick();
      if (pop_s && pop_cyc < 0) pop_cyc = k;
      if (acc_s) acc_cyc = k;
    end
    slv_req_valid = 1'b0;
    chk("full_accept_after_pop", 64'(acc_cyc - pop_cyc), 64'd1);
    drain();

    // Reset with two transactions outstanding
    rsp_en = '0; drive_tgt();
    send(64'h7800_0100, 1'b0);
    send(64'h7820_0100, 1'b0);
    chk("pre_rst_outstanding", {61'd0, outstanding}, 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_outstanding", {61'd0, outstanding}, 64'd0);
    chk("midrst_rsp_valid", {63'd0, slv_rsp_valid}, 64'd0);
    rsp_en = '1; drive_tgt();
    tick();
    chk("late_rsp_ready", {59'd0, mst_rsp_ready}, 64'd0);
    chk("late_rsp_valid", {63'd0, slv_rsp_valid}, 64'd0);
    for (int i = 0; i < NT; i++) tcnt[i] = 0;
    drive_tgt();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/carfield_l2_periph_router.md
Name: carfield_l2_periph_router

Overview:
- Single-master to multi-target request router. Sits directly upstream of the L2 dual-port, Spatz cluster, mailbox and peripheral address windows.
- Decodes each request address against the platform address map and forwards the request to exactly one target.
- Tracks outstanding transactions in an order FIFO and returns responses to the master strictly in issue order.
- Unmapped addresses are answered internally with an error response.

Parameters:
- NumTgt, 5: number of target ports.
- AddrWidth, 64: address width, matching doub_bt.
- DataWidth, 64: data width; byte-enable width is DataWidth/8.
- MaxTxns, 4: order FIFO depth, i.e. the maximum number of outstanding transactions.
- TgtEnable, {1,1,1,1,1}: per-target enable; a disabled target never matches.
- TgtBase, {'h78000000,'h78200000,'h51000000,'h40000000,'h20001000}: target base addresses (L2 port 0, L2 port 1, Spatz, Mailbox, Periph).
- TgtSize, {'h200000,'h200000,'h800000,'h1000,'h9000}: target window sizes in bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- slv_req_valid_i  in  1  master request valid.
- slv_req_ready_o  out  1  master request accepted.
- slv_req_addr_i  in  AddrWidth  request address.
- slv_req_we_i  in  1  write enable.
- slv_req_wdata_i  in  DataWidth  write data.
- slv_req_be_i  in  DataWidth/8  byte enables.
- slv_rsp_valid_o  out  1  response valid.
- slv_rsp_ready_i  in  1  master ready for response.
- slv_rsp_rdata_o  out  DataWidth  read data.
- slv_rsp_err_o  out  1  response error.
- mst_req_valid_o  out  NumTgt  per-target request valid.
- mst_req_ready_i  in  NumTgt  per-target request ready.
- mst_req_addr_o  out  AddrWidth  broadcast address, passed through unmodified.
- mst_req_we_o  out  1  broadcast write enable.
- mst_req_wdata_o  out  DataWidth  broadcast write data.
- mst_req_be_o  out  DataWidth/8  broadcast byte enables.
- mst_rsp_valid_i  in  NumTgt  per-target response valid.
- mst_rsp_ready_o  out  NumTgt  per-target response ready.
- mst_rsp_rdata_i  in  NumTgt*DataWidth  per-target read data (target i at slice i).
- mst_rsp_err_i  in  NumTgt  per-target response error.
- outstanding_o  out  $clog2(MaxTxns+1)  current order-FIFO occupancy.

Behaviour:
- Reset (rst_ni low, sampled on clk_i edge):
  - FIFO is emptied; outstanding_o=0.
  - All registered state clears.
  - Combinational outputs settle to: slv_rsp_valid_o=0, mst_rsp_ready_o=0, slv_req_ready_o=1 when the addressed target is ready or the address misses.
- Decode (combinational):
  - Target i hits when TgtEnable[i] && addr >= TgtBase[i] && addr < TgtBase[i]+TgtSize[i].
  - The sum is computed at AddrWidth+1 bits, so no wrap occurs.
  - On overlapping windows the lowest index wins.
  - No hit selects the internal error target, encoded as index NumTgt.
- Request path (zero latency, combinational):
  - mst_req_valid_o[sel] = slv_req_valid_i && !full; all other bits are 0.
  - Request payload is broadcast to all targets unmodified.
  - slv_req_ready_o = !full && (miss || mst_req_ready_i[sel]).
  - Accept = slv_req_valid_i && slv_req_ready_o; on accept, push sel into the FIFO.
  - A miss is accepted in one cycle whenever the FIFO is not full.
- Full handling:
  - full means occupancy == MaxTxns.
  - While full, a request is not accepted even if a pop occurs in the same cycle.
  - A push and pop in the same cycle at non-full occupancy leaves occupancy unchanged.
- Response path:
  - head = FIFO head entry.
  - FIFO empty: slv_rsp_valid_o=0 and all mst_rsp_ready_o=0, so stray target responses are never consumed.
  - head < NumTgt:
    - slv_rsp_valid_o = mst_rsp_valid_i[head].
    - rdata and err are taken from target head.
    - mst_rsp_ready_o[head] = slv_rsp_ready_i; all other ready bits stay 0.
  - head == NumTgt (error entry): slv_rsp_valid_o=1 with rdata=0 and err=1, presented in the cycle the entry reaches the head.
  - Pop on slv_rsp_valid_o && slv_rsp_ready_i.
  - Responses from non-head targets stall until their entry reaches the head. This preserves issue order across targets.
  - Response outputs are combinational from the target inputs; the router adds no response latency.
- outstanding_o equals the registered FIFO count, updated on the clock edge after a push or pop.
- Reset asserted mid-transaction discards all FIFO entries. Responses returned by targets after reset are not consumed.

Test Plan:
- Write to 'h78000010, target 0 ready → mst_req_valid_o=5'b00001, accepted in the same cycle. Target 0 responds err=0 → slv_rsp_err_o=0, outstanding_o returns 1→0.
- Read 'h78200000 then 'h40000008, target 3 responds before target 1 → slv_rsp shows target 1 data first, then target 3 data. mst_rsp_ready_o[3] stays 0 until target 1 pops.
- Read 'h10000000 (unmapped) → no mst_req_valid_o bit set. slv_rsp_valid_o=1 next cycle with err=1, rdata=0.
- Boundary addresses: 'h781FFFFF→target 0; 'h78200000→target 1; 'h20009FFF→target 4; 'h2000A000→error.
- Issue 4 requests with no responses → outstanding_o=4, slv_req_ready_o=0 for a fifth request. Fifth is accepted the cycle after the first pop.
- 2 outstanding, assert rst_ni=0 for one cycle → outstanding_o=0, slv_rsp_valid_o=0. A late target response sees mst_rsp_ready_o=0.
